// File: rtl/memarb_pkg.sv
// Shared types for mem_arbiter: access modes, FSM states and the latched request.
package memarb_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } io_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    io_mode_e    mode;
    logic [31:0] wdata;
  } req_t;

  // Encoding 3 is accepted on the port and treated as a word access.
  function automatic io_mode_e to_mode(input logic [1:0] m);
    io_mode_e r;
    case (m)
      2'd0:    r = BYTE;
      2'd1:    r = HALF;
      default: r = WORD;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lane, input io_mode_e mode);
    logic r;
    case (mode)
      HALF:    r = lane[0];
      WORD:    r = (lane != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_lane.sv
// mem_lane_align: combinational byte/halfword lane placement for writes and
// lane extraction for reads; misaligned sub-word addresses resolve aligned-down.
module mem_lane_align
  import memarb_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [1:0]  mode_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  io_mode_e mode;

  always_comb begin
    mode         = io_mode_e'(mode_i);
    misaligned_o = is_misaligned(lane_i, mode);
    wmask_o      = 4'hF;
    wdata_o      = wdata_i;
    rdata_o      = mem_rdata_i;
    case (mode)
      BYTE: begin
        wmask_o = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, 8'(mem_rdata_i >> {lane_i, 3'b000})};
      end
      HALF: begin
        // Only addr[1] selects the half, so an odd address falls to its aligned half.
        wmask_o = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, 16'(mem_rdata_i >> {lane_i[1], 4'b0000})};
      end
      default: begin
        wmask_o = 4'hF;
        wdata_o = wdata_i;
        rdata_o = mem_rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter sequencing single-port RAM accesses.
// Define MEMARB_MISALIGN_TRAP_EN to trap misaligned accesses with err_p instead of aligning down.
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_0,
  input  logic [31:0]       req_addr_0,
  input  logic              req_we_0,
  input  logic [1:0]        req_mode_0,
  input  logic [31:0]       req_wdata_0,
  output logic              done_0,
  output logic [31:0]       rdata_0,
  output logic              err_0,
  input  logic              req_valid_1,
  input  logic [31:0]       req_addr_1,
  input  logic              req_we_1,
  input  logic [1:0]        req_mode_1,
  input  logic [31:0]       req_wdata_1,
  output logic              done_1,
  output logic [31:0]       rdata_1,
  output logic              err_1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   err_q, err_d;

  req_t   cand;
  logic   cand_grant;
  req_t   align_req;
  logic [3:0]  lane_wmask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_misaligned;
  logic [31:0] resp_rdata;

  always_comb begin
    if (req_valid_0 && req_valid_1) cand_grant = ~last_grant_q;
    else                            cand_grant = req_valid_1;
    if (cand_grant)
      cand = '{addr: req_addr_1, we: req_we_1, mode: to_mode(req_mode_1), wdata: req_wdata_1};
    else
      cand = '{addr: req_addr_0, we: req_we_0, mode: to_mode(req_mode_0), wdata: req_wdata_0};
  end

  // In IDLE the aligner classifies the incoming winner; afterwards it serves the latched request.
  assign align_req = (state_q == IDLE) ? cand : req_q;

  mem_lane_align u_lane (
    .lane_i       (align_req.addr[1:0]),
    .mode_i       (align_req.mode),
    .wdata_i      (align_req.wdata),
    .mem_rdata_i  (mem_rdata),
    .wmask_o      (lane_wmask),
    .wdata_o      (lane_wdata),
    .rdata_o      (lane_rdata),
    .misaligned_o (lane_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_0 || req_valid_1) begin
          req_d        = cand;
          grant_d      = cand_grant;
          last_grant_d = cand_grant;
          err_d        = 1'b0;
          state_d      = ACCESS;
`ifdef MEMARB_MISALIGN_TRAP_EN
          if (lane_misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en     = (state_q == ACCESS);
    mem_we     = mem_en && req_q.we;
    mem_wmask  = mem_we ? lane_wmask : '0;
    mem_addr   = req_q.addr[ADDR_W+1:2];
    mem_wdata  = lane_wdata;
    done_0     = (state_q == RESP) && !grant_q;
    done_1     = (state_q == RESP) &&  grant_q;
    resp_rdata = err_q ? '0 : lane_rdata;
    rdata_0    = done_0 ? resp_rdata : '0;
    rdata_1    = done_1 ? resp_rdata : '0;
`ifdef MEMARB_MISALIGN_TRAP_EN
    err_0      = done_0 && err_q;
    err_1      = done_1 && err_q;
`else
    err_0      = 1'b0;
    err_1      = 1'b0;
`endif
  end

endmodule
